// File: rtl/alu_pkg.sv
// alu_pkg -- shared ALU result definitions.
// Holds the default result width, the flag bit positions, and the packed flags
// type {ovf, zero, neg, cout} used by the ALU and its write-back buffer.
// Optional feature macro in this slice: ALU_WB_STICKY_EN (see alu_wb_buffer).
package alu_pkg;

  localparam int DW_DEFAULT = 32;

  localparam int FLG_COUT = 0;
  localparam int FLG_NEG  = 1;
  localparam int FLG_ZERO = 2;
  localparam int FLG_OVF  = 3;

  // Field order places cout at bit 0 and ovf at bit 3, matching FLG_* above.
  typedef struct packed {
    logic ovf;
    logic zero;
    logic neg;
    logic cout;
  } alu_flags_t;

  function automatic alu_flags_t pack_flags(input logic cout, input logic neg,
                                            input logic zero, input logic ovf);
    alu_flags_t f;
    f.cout = cout;
    f.neg  = neg;
    f.zero = zero;
    f.ovf  = ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu_wb_buffer_if.sv
// alu_wb_buffer_if -- producer/consumer bundle around the ALU write-back buffer.
// Signals:
//   in_valid/in_ready, in_y, in_cout/in_neg/in_zero/in_ovf : ALU result input side
//   out_valid/out_ready, out_y, out_flags                   : head entry output side
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// valid never depends on ready; the buffer's ready never depends on the other
// side's ready, and data is held stable while valid=1 and ready=0.
// Modports: master = ALU producer plus consumer (the environment), slave = buffer.
interface alu_wb_buffer_if #(
  parameter int DW = alu_pkg::DW_DEFAULT
);
  import alu_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_y;
  logic          in_cout;
  logic          in_neg;
  logic          in_zero;
  logic          in_ovf;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_y;
  alu_flags_t    out_flags;

  modport master (
    output in_valid, in_y, in_cout, in_neg, in_zero, in_ovf, out_ready,
    input  in_ready, out_valid, out_y, out_flags
  );

  modport slave (
    input  in_valid, in_y, in_cout, in_neg, in_zero, in_ovf, out_ready,
    output in_ready, out_valid, out_y, out_flags
  );

endinterface

// File: rtl/alu_wb_mem.sv
// alu_wb_mem -- DEPTH x W register array for the write-back buffer.
// Ports:
//   clk   : write clock
//   we    : write enable, writes wdata to mem[waddr] at the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : asynchronous read address
//   rdata : mem[raddr], combinational
// Contents are not reset; the owner qualifies rdata with its own occupancy.
module alu_wb_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 36,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer -- in-order buffer of ALU results {Y, flags} between the ALU
// and the register write-back stage.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : alu_wb_buffer_if.slave (in_* push side, out_* pop side)
//   count        : current occupancy, 0..DEPTH
//   clr_sticky   : clears the accumulated flags (sticky build only)
//   sticky_flags : OR of the flags of every pushed entry, packed like out_flags
// Build option: define ALU_WB_STICKY_EN to include the sticky flag register;
// otherwise sticky_flags is tied to 0 and clr_sticky is ignored.
module alu_wb_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = DW_DEFAULT,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_wb_buffer_if.slave bus,
  output logic [CW-1:0]  count,
  input  logic           clr_sticky,
  output alu_flags_t     sticky_flags
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  alu_flags_t    in_flags;
  logic [DW+3:0] rdata;

  // Ready/valid come straight from the registered count, so neither side sees
  // a combinational path from the other side's handshake.
  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = (count != '0);

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  assign in_flags = pack_flags(bus.in_cout, bus.in_neg, bus.in_zero, bus.in_ovf);

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  alu_wb_mem #(
    .DEPTH (DEPTH),
    .W     (DW + 4)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_flags, bus.in_y}),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Gating by out_valid makes the output read 0 when empty, including right
  // after reset when the array still holds stale or unknown contents.
  assign bus.out_y     = bus.out_valid ? rdata[DW-1:0] : '0;
  assign bus.out_flags = bus.out_valid ? alu_flags_t'(rdata[DW+3:DW]) : '0;

`ifdef ALU_WB_STICKY_EN
  // Clear and accumulate in one expression: a push in the clearing cycle still
  // leaves its flags set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= '0;
    end else begin
      sticky_flags <= (clr_sticky ? alu_flags_t'(4'b0000) : sticky_flags)
                    | (push ? in_flags : alu_flags_t'(4'b0000));
    end
  end
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_flags      = '0;
`endif

endmodule

// File: tb/tb_alu_wb_buffer.sv
// tb_alu_wb_buffer -- directed bench for alu_wb_buffer (DEPTH=4, DW=32).
// Inputs are applied just after a rising edge and outputs are sampled 1ns after
// the following edge. The sticky-flag checks follow the ALU_WB_STICKY_EN build
// option.
module tb_alu_wb_buffer;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_sticky;
  logic [2:0] count;
  alu_flags_t sticky_flags;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] exp_q [$];

  alu_wb_buffer_if #(.DW(DW)) bus ();

  alu_wb_buffer #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .count        (count),
    .clr_sticky   (clr_sticky),
    .sticky_flags (sticky_flags)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [DW-1:0] y, input logic [3:0] f);
    bus.in_valid = 1'b1;
    bus.in_y     = y;
    bus.in_cout  = f[0];
    bus.in_neg   = f[1];
    bus.in_zero  = f[2];
    bus.in_ovf   = f[3];
  endtask

  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.in_y     = '0;
    bus.in_cout  = 1'b0;
    bus.in_neg   = 1'b0;
    bus.in_zero  = 1'b0;
    bus.in_ovf   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n         = 1'b0;
    clr_sticky    = 1'b0;
    bus.out_ready = 1'b0;
    drive_idle();

    // Reset state
    #2;
    chk("rst_count",     64'(count),         64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_y",     64'(bus.out_y),     64'd0);
    chk("rst_out_flags", 64'(bus.out_flags), 64'd0);
    chk("rst_sticky",    64'(sticky_flags),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single push, one-cycle latency
    drive_push(32'h0000_0005, 4'b0000);
    step();
    drive_idle();
    chk("lat_out_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_out_y",     64'(bus.out_y),     64'h5);
    chk("lat_count",     64'(count),         64'd1);
    chk("lat_flags",     64'(bus.out_flags), 64'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("empty_count", 64'(count),     64'd0);
    chk("empty_out_y", 64'(bus.out_y), 64'd0);

    // Fill to DEPTH with Y=1..4, flags=i
    for (int i = 1; i <= 4; i++) begin
      drive_push(32'(i), 4'(i));
      step();
      chk("fill_count", 64'(count), 64'(i));
    end
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    drive_push(32'h0000_0009, 4'b1111);
    step();
    chk("full_push_ignored", 64'(count),     64'd4);
    chk("full_head_y",       64'(bus.out_y), 64'd1);
    chk("full_head_flags",   64'(bus.out_flags), 64'd1);

    // Full with push and pop in the same cycle: pop only
    drive_push(32'h0000_00AA, 4'b1010);
    bus.out_ready = 1'b1;
    step();
    drive_idle();
    chk("full_pp_count", 64'(count),         64'd3);
    chk("full_pp_head",  64'(bus.out_y),     64'd2);
    chk("full_pp_flags", 64'(bus.out_flags), 64'd2);
    chk("drain_y2", 64'(bus.out_y), 64'd2);
    step();
    chk("drain_y3", 64'(bus.out_y), 64'd3);
    step();
    chk("drain_y4", 64'(bus.out_y), 64'd4);
    chk("drain_f4", 64'(bus.out_flags), 64'd4);
    step();
    chk("drain_count", 64'(count),         64'd0);
    chk("drain_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;

    // Steady push+pop at count=2 across pointer wrap
    drive_push(32'h10, 4'b0000);
    step();
    exp_q.push_back(32'h10);
    drive_push(32'h11, 4'b0000);
    step();
    exp_q.push_back(32'h11);
    chk("pp_start_count", 64'(count), 64'd2);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive_push(32'(32'h20 + k), 4'b0000);
      chk("pp_head", 64'(bus.out_y), 64'(exp_q[0]));
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(32'(32'h20 + k));
      chk("pp_count", 64'(count), 64'd2);
    end
    drive_idle();
    while (exp_q.size() > 0) begin
      chk("pp_drain", 64'(bus.out_y), 64'(exp_q[0]));
      step();
      void'(exp_q.pop_front());
    end
    chk("pp_end_count", 64'(count), 64'd0);
    bus.out_ready = 1'b0;

    // Sticky flags: clear, accumulate, clear with same-cycle push
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("sticky_cleared", 64'(sticky_flags), 64'd0);
    drive_push(32'h21, 4'b0001);
    step();
    drive_push(32'h22, 4'b1000);
    step();
`ifdef ALU_WB_STICKY_EN
    chk("sticky_acc", 64'(sticky_flags), 64'b1001);
`else
    chk("sticky_off", 64'(sticky_flags), 64'd0);
`endif
    drive_push(32'h23, 4'b0100);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    drive_idle();
`ifdef ALU_WB_STICKY_EN
    chk("sticky_clr_push", 64'(sticky_flags), 64'b0100);
`else
    chk("sticky_off2", 64'(sticky_flags), 64'd0);
`endif
    chk("pre_rst_count", 64'(count),     64'd3);
    chk("pre_rst_head",  64'(bus.out_y), 64'h21);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count",     64'(count),         64'd0);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("arst_out_y",     64'(bus.out_y),     64'd0);
    chk("arst_sticky",    64'(sticky_flags),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_count", 64'(count),         64'd0);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
    drive_push(32'h77, 4'b0110);
    step();
    drive_idle();
    chk("post_rst_push_count", 64'(count),         64'd1);
    chk("post_rst_push_y",     64'(bus.out_y),     64'h77);
    chk("post_rst_push_flags", 64'(bus.out_flags), 64'b0110);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_wb_buffer.md
ALU_WB_BUFFER -- requirements
Module: alu_wb_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL be the number of buffered ALU result entries (power of two, 2..16).
REQ-002 Parameter DW, default 32, SHALL be the result data width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark a valid ALU result on in_y/in_cout/in_neg/in_zero/in_ovf.
REQ-006 in_ready  output  1  SHALL indicate the buffer can accept an entry this cycle.
REQ-007 in_y  input  DW  SHALL carry ALU result Y.
REQ-008 in_cout, in_neg, in_zero, in_ovf  input  1 each  SHALL carry ALU Cout, Negative, Zero, Overflow.
REQ-009 out_valid  output  1  SHALL mark out_y/out_flags as a valid entry.
REQ-010 out_ready  input  1  SHALL indicate the consumer takes the head entry this cycle.
REQ-011 out_y  output  DW  SHALL be the head entry result.
REQ-012 out_flags  output  4  SHALL be head entry flags packed {ovf, zero, neg, cout}.
REQ-013 count  output  $clog2(DEPTH)+1  SHALL be the current occupancy.
REQ-014 clr_sticky  input  1  SHALL clear the sticky flag register (when compiled in).
REQ-015 sticky_flags  output  4  SHALL be the accumulated flags, packed as out_flags.

Function
REQ-016 A push SHALL occur when in_valid && in_ready; a pop when out_valid && out_ready.
REQ-017 in_ready SHALL equal (count != DEPTH), independent of out_ready (no combinational ready path).
REQ-018 out_valid SHALL equal (count != 0); out_y/out_flags SHALL be driven from registered storage only.
REQ-019 Latency: an entry pushed at edge N SHALL be visible with out_valid=1 after edge N (one cycle) when the buffer was empty.
REQ-020 Entries SHALL pop in push order; head/tail pointers SHALL wrap modulo DEPTH.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, including when count==DEPTH-... non-full; when full, push is blocked (in_ready=0) and only the pop occurs.
REQ-022 Pop with count==0 and push with count==DEPTH SHALL be ignored with no state change.
REQ-023 out_y/out_flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 When empty, out_y and out_flags SHALL read 0.

Reset
REQ-025 rst_n=0 SHALL immediately force count=0, pointers=0, out_valid=0, in_ready=1, out_y=0, out_flags=0, sticky_flags=0, regardless of clk.
REQ-026 Reset mid-operation SHALL discard all buffered entries; first edge after release behaves as empty buffer.

Configuration
REQ-027 Macro ALU_WB_STICKY_EN defined: sticky_flags SHALL OR in the flags of every pushed entry at the push edge; clr_sticky=1 clears at the edge, but a same-cycle push's flags SHALL still be set (push wins).
REQ-028 ALU_WB_STICKY_EN undefined: sticky_flags SHALL be constant 0, clr_sticky ignored, no sticky register synthesised; port list unchanged.

Structure
REQ-029 Package alu_pkg SHALL hold DW default, flag bit index constants (FLG_COUT=0, FLG_NEG=1, FLG_ZERO=2, FLG_OVF=3) and a packed 4-bit flags typedef shared with the ALU.
REQ-030 Storage SHALL be a sub-module alu_wb_mem (DEPTH x (DW+4) register array, one write port, one async read port); pointer/count control stays in alu_wb_buffer.

Verification
REQ-031 Reset then push Y=0x0000_0005 flags=0000, out_ready=0 -> next cycle out_valid=1, out_y=0x5, count=1.
REQ-032 Push 4 entries (Y=1..4) with out_ready=0 -> count=4, in_ready=0; 5th push ignored; drain -> out_y 1,2,3,4 in order.
REQ-033 Full buffer, in_valid=1 and out_ready=1 same cycle -> pop only, count 4->3, pushed data not stored.
REQ-034 Count=2, simultaneous push/pop for 10 cycles -> count stays 2, order preserved across pointer wrap.
REQ-035 STICKY_EN: push flags 0001 then 1000 -> sticky=1001; clr_sticky with push of 0100 same cycle -> sticky=0100.
REQ-036 Assert rst_n=0 asynchronously mid-cycle with count=3 -> count=0, out_valid=0 before next clk edge.
